// File: rtl/ooop_types.sv
// Shared out-of-order pipeline types: ROB geometry and the branch recovery
// sequencer state encoding.
package ooop_types;

  localparam int unsigned ROB_W      = 4;
  localparam int unsigned ROB_DEPTH  = 1 << ROB_W;
  localparam int unsigned WALK_CNT_W = ROB_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    WALK     = 2'd2,
    REDIRECT = 2'd3
  } recov_state_t;

endpackage

// File: rtl/branch_recovery_seq_if.sv
// Recovery sequencer bundle: branch-unit capture inputs, rename rollback walk
// and fetch redirect handshakes.
interface branch_recovery_seq_if #(
  parameter int unsigned ROB_W = ooop_types::ROB_W
) ();

  logic             mispredict_i;
  logic [ROB_W-1:0] recover_tag_i;
  logic [31:0]      target_pc_i;
  logic [ROB_W-1:0] rob_tail_i;
  logic             walk_ready_i;
  logic             redirect_ready_i;

  logic             flush_o;
  logic             walk_valid_o;
  logic [ROB_W-1:0] walk_tag_o;
  logic             redirect_valid_o;
  logic [31:0]      redirect_pc_o;
  logic             busy_o;

  modport master (
    output mispredict_i, recover_tag_i, target_pc_i, rob_tail_i,
           walk_ready_i, redirect_ready_i,
    input  flush_o, walk_valid_o, walk_tag_o, redirect_valid_o,
           redirect_pc_o, busy_o
  );

  modport slave (
    input  mispredict_i, recover_tag_i, target_pc_i, rob_tail_i,
           walk_ready_i, redirect_ready_i,
    output flush_o, walk_valid_o, walk_tag_o, redirect_valid_o,
           redirect_pc_o, busy_o
  );

endinterface

// File: rtl/branch_recovery_seq.sv
// Branch mispredict recovery: one-cycle squash, youngest-first ROB rollback
// walk down to (not including) the branch, then fetch redirect.
module branch_recovery_seq #(
  parameter int unsigned ROB_W = ooop_types::ROB_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_recovery_seq_if.slave  rec
);

  import ooop_types::*;

  localparam logic [ROB_W-1:0] ONE = ROB_W'(1);

  recov_state_t     state_q;
  logic [ROB_W-1:0] tag_q;
  logic [ROB_W-1:0] tail_q;
  logic [31:0]      pc_q;

  logic             flush_q;
  logic             walk_valid_q;
  logic [ROB_W-1:0] walk_tag_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;

  // Entries strictly younger than the branch: tail-1 down to tag+1.
  logic [ROB_W-1:0] walk_cnt;
  assign walk_cnt = tail_q - tag_q - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      tag_q            <= '0;
      tail_q           <= '0;
      pc_q             <= '0;
      flush_q          <= 1'b0;
      walk_valid_q     <= 1'b0;
      walk_tag_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rec.mispredict_i) begin
            tag_q   <= rec.recover_tag_i;
            tail_q  <= rec.rob_tail_i;
            pc_q    <= rec.target_pc_i;
            flush_q <= 1'b1;
            state_q <= FLUSH;
          end
        end

        FLUSH: begin
          if (walk_cnt != '0) begin
            walk_valid_q <= 1'b1;
            walk_tag_q   <= tail_q - ONE;
            state_q      <= WALK;
          end else begin
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= pc_q;
            state_q          <= REDIRECT;
          end
        end

        WALK: begin
          if (rec.walk_ready_i) begin
            if (walk_tag_q == tag_q + ONE) begin
              walk_valid_q     <= 1'b0;
              walk_tag_q       <= '0;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= pc_q;
              state_q          <= REDIRECT;
            end else begin
              walk_tag_q <= walk_tag_q - ONE;
            end
          end
        end

        REDIRECT: begin
          if (rec.redirect_ready_i) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            state_q          <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rec.flush_o          = flush_q;
  assign rec.walk_valid_o     = walk_valid_q;
  assign rec.walk_tag_o       = walk_tag_q;
  assign rec.redirect_valid_o = redirect_valid_q;
  assign rec.redirect_pc_o    = redirect_pc_q;
  assign rec.busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_branch_recovery_seq.sv
// Directed bench for branch_recovery_seq: expected flush/walk/redirect events
// are queued at mispredict time and retired as the DUT handshakes them.
module tb_branch_recovery_seq;

  localparam int unsigned ROB_W = 4;

  typedef struct {
    int          kind;   // 0 flush, 1 walk transfer, 2 redirect handshake
    logic [31:0] val;
    int          cyc;    // -1 when timing is not constrained
  } ev_t;

  logic clk;
  logic rst_n;

  branch_recovery_seq_if #(.ROB_W(ROB_W)) bus ();

  branch_recovery_seq #(.ROB_W(ROB_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rec   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  passed = 0;
  int  cyc    = 0;
  ev_t q[$];

  logic             prev_wv, prev_wr, prev_rv, prev_rr;
  logic [ROB_W-1:0] prev_wt;
  logic [31:0]      prev_pc;
  logic             pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic observe(input int kind, input logic [31:0] val);
    ev_t e;
    check("sb_pending", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_value", val, e.val);
      if (e.cyc >= 0) check("sb_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Called mid-cycle with this cycle's inputs driven; retires handshakes, then
  // advances to the middle of the next cycle.
  task automatic tick();
    if (bus.flush_o) observe(0, 32'd0);
    if (bus.walk_valid_o && bus.walk_ready_i) observe(1, 32'(bus.walk_tag_o));
    if (bus.redirect_valid_o && bus.redirect_ready_i) observe(2, bus.redirect_pc_o);
    if (!bus.walk_valid_o) check("walk_tag_idle_zero", 32'(bus.walk_tag_o), 32'd0);
    if (!bus.redirect_valid_o) check("redirect_pc_idle_zero", bus.redirect_pc_o, 32'd0);
    if (prev_wv && !prev_wr) begin
      check("walk_hold_valid", 32'(bus.walk_valid_o), 32'd1);
      check("walk_hold_tag", 32'(bus.walk_tag_o), 32'(prev_wt));
    end
    if (prev_rv && !prev_rr) begin
      check("redirect_hold_valid", 32'(bus.redirect_valid_o), 32'd1);
      check("redirect_hold_pc", bus.redirect_pc_o, prev_pc);
    end
    prev_wv = bus.walk_valid_o;
    prev_wr = bus.walk_ready_i;
    prev_wt = bus.walk_tag_o;
    prev_rv = bus.redirect_valid_o;
    prev_rr = bus.redirect_ready_i;
    prev_pc = bus.redirect_pc_o;
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_recovery(input logic [ROB_W-1:0] tag, input logic [ROB_W-1:0] tail,
                               input logic [31:0] pc, input bit timed);
    int               t0;
    logic [ROB_W-1:0] n;
    logic [ROB_W-1:0] wt;
    t0 = cyc;
    n  = tail - tag - 4'd1;
    wt = tail;
    q.push_back('{0, 32'd0, timed ? t0 + 1 : -1});
    for (int i = 0; i < int'(n); i++) begin
      wt = wt - 4'd1;
      q.push_back('{1, 32'(wt), timed ? t0 + 2 + i : -1});
    end
    q.push_back('{2, pc, timed ? t0 + 2 + int'(n) : -1});
  endtask

  task automatic launch(input logic [ROB_W-1:0] tag, input logic [ROB_W-1:0] tail,
                        input logic [31:0] pc, input bit timed);
    bus.mispredict_i  = 1'b1;
    bus.recover_tag_i = tag;
    bus.rob_tail_i    = tail;
    bus.target_pc_i   = pc;
    push_recovery(tag, tail, pc, timed);
    tick();
    bus.mispredict_i = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_complete", 32'(q.size()), 32'd0);
  endtask

  task automatic stray_pulse(input logic [ROB_W-1:0] tag, input logic [ROB_W-1:0] tail,
                             input logic [31:0] pc);
    bus.mispredict_i  = 1'b1;
    bus.recover_tag_i = tag;
    bus.rob_tail_i    = tail;
    bus.target_pc_i   = pc;
    tick();
    bus.mispredict_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rw;
    rst_n                = 1'b0;
    bus.mispredict_i     = 1'b0;
    bus.recover_tag_i    = '0;
    bus.rob_tail_i       = '0;
    bus.target_pc_i      = '0;
    bus.walk_ready_i     = 1'b1;
    bus.redirect_ready_i = 1'b1;
    prev_wv = 1'b0; prev_wr = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0;
    prev_wt = '0;   prev_pc = '0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_flush", 32'(bus.flush_o), 32'd0);
    check("rst_walk_valid", 32'(bus.walk_valid_o), 32'd0);
    check("rst_redirect_valid", 32'(bus.redirect_valid_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Basic: tag 3, tail 7 -> walk 6,5,4, redirect 0x100 at T+5, idle at T+6
    launch(4'd3, 4'd7, 32'h100, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      check("basic_busy", 32'(bus.busy_o), (k <= 5) ? 32'd1 : 32'd0);
      tick();
    end
    check("basic_drained", 32'(q.size()), 32'd0);

    // Wrap-around: tag 14, tail 2 -> walk 1,0,15
    launch(4'd14, 4'd2, 32'h0000_2468, 1'b1);
    drain(20);

    // No walk, plus a mispredict on the returning handshake cycle (ignored)
    // followed by one on the next cycle (captured)
    launch(4'd5, 4'd6, 32'h300, 1'b1);
    check("nowalk_flush", 32'(bus.flush_o), 32'd1);
    tick();
    check("nowalk_redirect_valid", 32'(bus.redirect_valid_o), 32'd1);
    check("nowalk_walk_valid", 32'(bus.walk_valid_o), 32'd0);
    stray_pulse(4'd9, 4'd12, 32'hBAD0);
    launch(4'd7, 4'd9, 32'h400, 1'b1);
    drain(20);

    // Backpressure on walk (1,0,0,1,...) and redirect held off for 3 cycles
    launch(4'd1, 4'd6, 32'h7A0, 1'b0);
    rw = 0;
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      bus.walk_ready_i = pat[i % 4];
      if (bus.redirect_valid_o) begin
        bus.redirect_ready_i = (rw >= 3);
        rw++;
      end else begin
        bus.redirect_ready_i = 1'b0;
      end
      tick();
    end
    bus.walk_ready_i     = 1'b1;
    bus.redirect_ready_i = 1'b1;
    check("bp_redirect_wait", 32'(rw), 32'd4);
    drain(5);

    // Collisions during FLUSH and WALK are ignored; timing unchanged
    launch(4'd0, 4'd6, 32'h200, 1'b1);
    stray_pulse(4'd9, 4'd13, 32'hDEAD);
    tick();
    stray_pulse(4'd9, 4'd13, 32'hDEAD);
    drain(20);
    tick();
    check("collision_idle", 32'(bus.busy_o), 32'd0);

    // Asynchronous reset mid-walk abandons recovery
    launch(4'd2, 4'd10, 32'h500, 1'b0);
    tick();
    tick();
    tick();
    check("prereset_walking", 32'(bus.walk_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_flush", 32'(bus.flush_o), 32'd0);
    check("async_rst_walk_valid", 32'(bus.walk_valid_o), 32'd0);
    check("async_rst_walk_tag", 32'(bus.walk_tag_o), 32'd0);
    check("async_rst_redirect_valid", 32'(bus.redirect_valid_o), 32'd0);
    check("async_rst_redirect_pc", bus.redirect_pc_o, 32'd0);
    check("async_rst_busy", 32'(bus.busy_o), 32'd0);
    q.delete();
    prev_wv = 1'b0;
    prev_rv = 1'b0;
    @(negedge clk);
    cyc++;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("post_rst_busy", 32'(bus.busy_o), 32'd0);
      check("post_rst_walk_valid", 32'(bus.walk_valid_o), 32'd0);
      check("post_rst_redirect_valid", 32'(bus.redirect_valid_o), 32'd0);
      tick();
    end

    // Capture on the first posedge after reset release
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    launch(4'd4, 4'd5, 32'h600, 1'b1);
    drain(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
